bicubic_accum: RTL



---
 rtl/bicubic_pkg.sv | 48 ++++
 rtl/bicubic_round_clamp.sv | 38 +++
 rtl/bicubic_accum.sv | 87 ++++++++
 3 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants, types and helpers for the bicubic interpolation datapath.
// The multipliers, the weight generator and the accumulator all import this package.
package bicubic_pkg;

    localparam int unsigned PROD_W = 28;
    localparam int unsigned TAPS   = 16;
    localparam int unsigned FRAC   = 16;
    localparam int unsigned PIX_W  = 10;
    localparam int unsigned CNT_W  = $clog2(TAPS);
    localparam int unsigned ACC_W  = PROD_W + CNT_W + 2;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [CNT_W-1:0]        cnt_t;
    typedef logic [PIX_W-1:0]        pix_t;

    // One product beat as it arrives from the multiplier delay pipeline
    typedef struct packed {
        logic              sop;
        logic              neg;
        logic [PROD_W-1:0] mag;
    } prod_beat_t;

    localparam acc_t RND_HALF = acc_t'(64'd1 << (FRAC - 1));
    localparam acc_t PIX_MAX  = acc_t'((64'd1 << PIX_W) - 64'd1);

    // Zero-extend the product magnitude, then negate for a negative weight
    function automatic acc_t make_term(input logic [PROD_W-1:0] mag, input logic neg);
        acc_t m;
        m = acc_t'(mag);
        return neg ? -m : m;
    endfunction

    // Round half up on the fractional bits, then saturate to the pixel range
    function automatic pix_t clamp_round(input acc_t sum);
        acc_t rnd;
        acc_t r;
        rnd = sum + RND_HALF;
        r   = rnd >>> FRAC;
        if (r[ACC_W-1]) begin
            return '0;
        end else if (r > PIX_MAX) begin
            return '1;
        end else begin
            return r[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bicubic_round_clamp.sv
// Output stage: registers the rounded, clamped pixel of one completed tap sum.
// pix_out holds its last value between strobes.
module bicubic_round_clamp
    import bicubic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_vld,
    input  acc_t             sum,
    output logic             pix_vld,
    output logic [PIX_W-1:0] pix_out
);

    logic pix_vld_q, pix_vld_d;
    pix_t pix_out_q, pix_out_d;

    always_comb begin
        pix_vld_d = s1_vld;
        pix_out_d = pix_out_q;
        if (s1_vld) begin
            pix_out_d = clamp_round(sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_vld_q <= 1'b0;
            pix_out_q <= '0;
        end else begin
            pix_vld_q <= pix_vld_d;
            pix_out_q <= pix_out_d;
        end
    end

    assign pix_vld = pix_vld_q;
    assign pix_out = pix_out_q;

endmodule

// File: rtl/bicubic_accum.sv
// Accumulates TAPS signed pixel x weight products per output pixel, then
// rounds and clamps the sum into one output pixel strobe.
module bicubic_accum
    import bicubic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_vld,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_neg,
    input  logic              sop,
    output logic              pix_vld,
    output logic [PIX_W-1:0]  pix_out,
    output logic              grp_err
);

    prod_beat_t beat;
    acc_t       term;
    logic       grp_start;
    logic       grp_last;

    acc_t acc_q, acc_d;
    acc_t sum_q, sum_d;
    cnt_t cnt_q, cnt_d;
    logic s1_vld_q, s1_vld_d;
    logic grp_err_q, grp_err_d;

    // Stage 1: tap counting and accumulation; idle cycles leave state untouched
    always_comb begin
        beat      = '{sop: sop, neg: prod_neg, mag: prod};
        term      = make_term(beat.mag, beat.neg);
        grp_start = (cnt_q == '0) || beat.sop;
        grp_last  = (cnt_q == cnt_t'(TAPS - 1)) && !beat.sop;

        acc_d     = acc_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        s1_vld_d  = 1'b0;
        grp_err_d = 1'b0;

        if (prod_vld) begin
            // A sop landing mid-group abandons the partial sum
            grp_err_d = beat.sop && (cnt_q != '0);
            if (grp_start) begin
                acc_d = term;
                cnt_d = cnt_t'(1);
            end else if (grp_last) begin
                acc_d    = acc_q + term;
                sum_d    = acc_q + term;
                s1_vld_d = 1'b1;
                cnt_d    = '0;
            end else begin
                acc_d = acc_q + term;
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            grp_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            grp_err_q <= grp_err_d;
        end
    end

    // Stage 2: round and clamp
    bicubic_round_clamp u_round_clamp (
        .clk     (clk),
        .rst     (rst),
        .s1_vld  (s1_vld_q),
        .sum     (sum_q),
        .pix_vld (pix_vld),
        .pix_out (pix_out)
    );

    assign grp_err = grp_err_q;

endmodule
